processing_element: RTL and testbench

- Single weight-stationary multiply-accumulate cell of the N×N systolic matrix-multiply array.
- Holds one preloaded signed 8-bit weight.
- Each cycle it:
  - forwards its signed 8-bit activation east (data_out) with one register stage;
  - adds activation×weight to the partial sum arriving from the north, registering the result south (partial_sum_out).
- Instantiated ARRAY_SIZE² times. Array-level skew, valid tracking and output latching live outside this block.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/pe_mac.sv | 23 ++
 rtl/processing_element.sv | 42 ++++
 tb/tb_processing_element.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, types and helpers for the weight-stationary systolic array.
package systolic_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Sign-extend a full-width product into the accumulator width.
    function automatic logic [ACC_W-1:0] sext_product(input logic [2*DATA_W-1:0] product);
        sext_product = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
    endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply and wrap-around accumulate of one PE.
module pe_mac
    import systolic_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] weight,
    input  logic [ACC_W-1:0]  partial_sum_in,
    output logic [ACC_W-1:0]  mac_out
);

    logic [2*DATA_W-1:0] data_ext_s;
    logic [2*DATA_W-1:0] weight_ext_s;
    logic [2*DATA_W-1:0] product_s;

    // Operands widened to the product width first so the low half of the multiply is the exact signed product.
    always_comb begin
        data_ext_s   = {{DATA_W{data_in[DATA_W-1]}}, data_in};
        weight_ext_s = {{DATA_W{weight[DATA_W-1]}}, weight};
        product_s    = data_ext_s * weight_ext_s;
        mac_out      = partial_sum_in + sext_product(product_s);
    end

endmodule

// File: rtl/processing_element.sv
// Weight-stationary MAC cell: forwards activations east and accumulated sums south, both registered.
module processing_element
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              load_weight,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ACC_W-1:0]  partial_sum_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ACC_W-1:0]  partial_sum_out
);

    logic [DATA_W-1:0] weight_r;
    logic [ACC_W-1:0]  mac_sum_s;

    pe_mac u_mac (
        .data_in        (data_in),
        .weight         (weight_r),
        .partial_sum_in (partial_sum_in),
        .mac_out        (mac_sum_s)
    );

    // Pipeline registers; a weight loaded on an edge is first used on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_r        <= {DATA_W{1'b0}};
            data_out        <= {DATA_W{1'b0}};
            partial_sum_out <= {ACC_W{1'b0}};
        end else begin
            data_out        <= data_in;
            partial_sum_out <= mac_sum_s;
            if (load_weight) begin
                weight_r <= weight_in;
            end else begin
                weight_r <= weight_r;
            end
        end
    end

endmodule

// File: tb/tb_processing_element.sv
// Directed self-checking bench for processing_element.
module tb_processing_element;

    logic        clk;
    logic        rst;
    logic [7:0]  weight_in;
    logic        load_weight;
    logic [7:0]  data_in;
    logic [31:0] partial_sum_in;
    logic [7:0]  data_out;
    logic [31:0] partial_sum_out;

    int n_checks;
    int n_passed;

    processing_element dut (
        .clk             (clk),
        .rst             (rst),
        .weight_in       (weight_in),
        .load_weight     (load_weight),
        .data_in         (data_in),
        .partial_sum_in  (partial_sum_in),
        .data_out        (data_out),
        .partial_sum_out (partial_sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] w, input logic [7:0] d, input logic [31:0] ps);
        load_weight    = ld;
        weight_in      = w;
        data_in        = d;
        partial_sum_in = ps;
    endtask

    int exp_ps [4];

    initial begin
        n_checks = 0;
        n_passed = 0;
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 32'h0);
        #2;
        check("reset_data_out", {24'h0, data_out}, 32'h0);
        check("reset_psum", partial_sum_out, 32'h0);
        step();
        rst = 1'b0;

        // Nonzero activity, then an asynchronous mid-cycle reset.
        drive(1'b1, 8'd7, 8'd9, 32'd50);
        step();
        check("pre_rst_data", {24'h0, data_out}, 32'd9);
        check("pre_rst_psum_old_weight", partial_sum_out, 32'd50);
        drive(1'b0, 8'd7, 8'd9, 32'd50);
        step();
        check("pre_rst_psum", partial_sum_out, 32'd113);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_data", {24'h0, data_out}, 32'h0);
        check("async_rst_psum", partial_sum_out, 32'h0);
        #2;
        rst = 1'b0;
        drive(1'b0, 8'd0, 8'd5, 32'd0);
        step();
        check("weight_cleared_psum", partial_sum_out, 32'd0);
        check("post_rst_data", {24'h0, data_out}, 32'd5);

        // Load then compute.
        drive(1'b1, 8'd3, 8'd0, 32'd0);
        step();
        drive(1'b0, 8'd0, 8'd4, 32'd10);
        step();
        check("mac_3x4p10", partial_sum_out, 32'd22);
        check("fwd_4", {24'h0, data_out}, 32'd4);

        // Load/compute collision uses the old weight.
        drive(1'b1, 8'd2, 8'd0, 32'd0);
        step();
        drive(1'b1, 8'hFB, 8'd7, 32'd0);
        step();
        check("collision_old_weight", partial_sum_out, 32'd14);
        drive(1'b0, 8'd0, 8'd7, 32'd0);
        step();
        check("collision_new_weight", partial_sum_out, 32'hFFFF_FFDD);

        // Signed extremes.
        drive(1'b1, 8'h80, 8'd0, 32'd0);
        step();
        drive(1'b0, 8'd0, 8'h80, 32'd0);
        step();
        check("neg128_sq", partial_sum_out, 32'd16384);
        drive(1'b0, 8'd0, 8'h7F, 32'hFFFF_FFFF);
        step();
        check("neg128x127_m1", partial_sum_out, 32'hFFFF_C07F);
        check("fwd_127", {24'h0, data_out}, 32'h7F);

        // Accumulator wrap.
        drive(1'b1, 8'd1, 8'd0, 32'd0);
        step();
        drive(1'b0, 8'd0, 8'd1, 32'h7FFF_FFFF);
        step();
        check("wrap", partial_sum_out, 32'h8000_0000);

        // Streaming with a stationary weight of -3.
        exp_ps = '{32'd97, 32'd94, 32'd91, 32'd88};
        drive(1'b1, 8'hFD, 8'd0, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h55, 8'(i + 1), 32'd100);
            step();
            check($sformatf("stream_psum_%0d", i), partial_sum_out, 32'(exp_ps[i]));
            check($sformatf("stream_data_%0d", i), {24'h0, data_out}, 32'(i + 1));
        end

        // Idle zero activation passes the partial sum straight through.
        drive(1'b0, 8'd0, 8'd0, 32'd12345);
        step();
        check("zero_passthrough", partial_sum_out, 32'd12345);
        drive(1'b0, 8'd0, 8'd2, 32'd0);
        step();
        check("weight_stationary", partial_sum_out, 32'hFFFF_FFFA);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
